// File: rtl/gen_fifo_pkg.sv
// gen_fifo_pkg: shared mode encodings, FSM states and LFSR polynomial for the stream generator
package gen_fifo_pkg;
  typedef enum logic [1:0] {MODE_CNT = 2'd0, MODE_LFSR = 2'd1, MODE_CONST = 2'd2} mode_e;
  typedef enum logic {IDLE, GEN} state_e;
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; head word reads as zero when empty
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (ADDR_WIDTH+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_WIDTH'(do_push);
      rd_ptr <= rd_ptr + ADDR_WIDTH'(do_pop);
      count <= count + (ADDR_WIDTH+1)'(do_push) - (ADDR_WIDTH+1)'(do_pop);
    end
endmodule

// File: rtl/gen_fifo_stream.sv
// gen_fifo_stream: packetised counter/LFSR/constant word generator feeding an AXI-Stream FIFO
module gen_fifo_stream
  import gen_fifo_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int PKT_LEN_WIDTH = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [DATA_SIZE-1:0]     seed,
  input  logic [PKT_LEN_WIDTH-1:0] pkt_len,
  output logic [DATA_SIZE-1:0]     m00_axis_tdata,
  output logic [DATA_SIZE/8-1:0]   m00_axis_tstrb,
  output logic                     m00_axis_tvalid,
  input  logic                     m00_axis_tready,
  output logic                     m00_axis_tlast,
  output logic [ADDR_WIDTH:0]      fifo_count,
  output logic [15:0]              pkt_count,
  output logic                     busy
);
  localparam logic [DATA_SIZE-1:0] POLY = LFSR_POLY[DATA_SIZE-1:0];
  logic [1:0] rst_sync;
  logic rst_n;
  state_e state;
  logic [DATA_SIZE-1:0] value, next_value;
  logic [PKT_LEN_WIDTH-1:0] word_cnt, cur_len, len, len1;
  logic [1:0] cur_mode, md;
  logic first, last, push, pop, full, empty;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  assign first = word_cnt == PKT_LEN_WIDTH'(1);
  assign md = first ? mode : cur_mode;
  assign len = first ? pkt_len : cur_len;
  assign len1 = len == '0 ? PKT_LEN_WIDTH'(1) : len;
  assign last = word_cnt == len1;
  assign push = state == GEN && !full;
  assign pop = m00_axis_tvalid && m00_axis_tready;
  assign next_value = md == MODE_CONST ? value :
                      md == MODE_LFSR  ? (value >> 1) ^ (value[0] ? POLY : '0) :
                                         value + DATA_SIZE'(1);
  assign m00_axis_tvalid = !empty;
  assign m00_axis_tstrb = '1;
  assign busy = state == GEN;
  always_ff @(posedge aclk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      value <= '0;
      word_cnt <= PKT_LEN_WIDTH'(1);
      cur_mode <= MODE_CNT;
      cur_len <= '0;
    end else if (state == IDLE) begin
      if (enable) begin
        state <= GEN;
        value <= (mode == MODE_LFSR && seed == '0) ? DATA_SIZE'(1) : seed;
      end
    end else if (push) begin
      value <= next_value;
      word_cnt <= last ? PKT_LEN_WIDTH'(1) : word_cnt + PKT_LEN_WIDTH'(1);
      if (first) begin
        cur_mode <= mode;
        cur_len <= pkt_len;
      end
      if (last && !enable) state <= IDLE;
    end
  always_ff @(posedge aclk or negedge rst_n)
    if (!rst_n) pkt_count <= '0;
    else if (pop && m00_axis_tlast) pkt_count <= pkt_count + 16'd1;
  sync_fifo #(.WIDTH(DATA_SIZE + 1), .ADDR_WIDTH(ADDR_WIDTH)) u_fifo (
    .clk(aclk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din({last, value}),
    .dout({m00_axis_tlast, m00_axis_tdata}),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_gen_fifo_stream.sv
// tb_gen_fifo_stream: directed stimulus with a word-sequence scoreboard model of the generator
module tb_gen_fifo_stream;
  localparam int DS = 32;
  localparam int AW = 4;
  localparam int PW = 8;
  logic aclk = 0, aresetn = 0, enable = 0, tready = 0;
  logic [1:0] mode = 0;
  logic [DS-1:0] seed = 0;
  logic [PW-1:0] pkt_len = 1;
  logic [DS-1:0] tdata;
  logic [DS/8-1:0] tstrb;
  logic tvalid, tlast, busy;
  logic [AW:0] fifo_count;
  logic [15:0] pkt_count;
  int vectors = 0, miscompares = 0, n_pop = 0, model_pkts = 0;
  bit mon_en = 0;
  logic [DS-1:0] exp_data[$];
  bit exp_last[$];
  gen_fifo_stream #(.DATA_SIZE(DS), .ADDR_WIDTH(AW), .PKT_LEN_WIDTH(PW)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .enable(enable),
    .mode(mode),
    .seed(seed),
    .pkt_len(pkt_len),
    .m00_axis_tdata(tdata),
    .m00_axis_tstrb(tstrb),
    .m00_axis_tvalid(tvalid),
    .m00_axis_tready(tready),
    .m00_axis_tlast(tlast),
    .fifo_count(fifo_count),
    .pkt_count(pkt_count),
    .busy(busy)
  );
  always #5 aclk = ~aclk;
  task automatic chk(string nm, longint got, longint want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    end
  endtask
  function automatic logic [DS-1:0] step(logic [1:0] m, logic [DS-1:0] v);
    if (m == 2) return v;
    if (m == 1) return v[0] ? (v >> 1) ^ 32'h80200003 : v >> 1;
    return v + 1;
  endfunction
  task automatic build(logic [1:0] m, logic [DS-1:0] s, int len, int n);
    logic [DS-1:0] v = (m == 1 && s == 0) ? 1 : s;
    int l = len == 0 ? 1 : len;
    exp_data.delete();
    exp_last.delete();
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(v);
      exp_last.push_back((i + 1) % l == 0);
      v = step(m, v);
    end
  endtask
  always @(negedge aclk)
    if (mon_en) begin
      chk("tvalid_vs_count", tvalid, fifo_count != 0);
      chk("count_le_depth", fifo_count <= 16, 1);
      chk("pkt_count", pkt_count, model_pkts & 16'hffff);
      chk("tstrb", tstrb, 4'hf);
      if (tvalid && tready) begin
        if (exp_data.size() == 0) chk("extra_word", 1, 0);
        else begin
          chk("tdata", tdata, exp_data[0]);
          chk("tlast", tlast, exp_last[0]);
          if (exp_last[0]) model_pkts++;
          void'(exp_data.pop_front());
          void'(exp_last.pop_front());
        end
        n_pop++;
      end else if (tvalid && exp_data.size() > 0) chk("hold_head", tdata, exp_data[0]);
    end
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask
  task automatic start(logic [1:0] m, logic [DS-1:0] s, int len, bit rdy);
    mode = m;
    seed = s;
    pkt_len = len[PW-1:0];
    build(m, s, len, 400);
    n_pop = 0;
    tready = rdy;
    enable = 1;
  endtask
  task automatic wait_pop(int n);
    int t = 0;
    while (n_pop < n && t < 2000) begin
      tick();
      t++;
    end
    chk("wait_pop_reached", n_pop >= n, 1);
  endtask
  task automatic finish_stream(int l);
    int t = 0;
    enable = 0;
    tready = 1;
    while ((busy || tvalid) && t < 500) begin
      tick();
      t++;
    end
    chk("idle_reached", busy || tvalid, 0);
    chk("whole_packets", n_pop % l, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int t;
    repeat (3) tick();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_busy", busy, 0);
    aresetn = 1;
    repeat (3) tick();
    mon_en = 1;
    start(0, 100, 4, 1);
    chk("pin_cnt_w0", exp_data[0], 100);
    chk("pin_cnt_w3_last", exp_last[3], 1);
    chk("pin_cnt_w4", exp_data[4], 104);
    wait_pop(8);
    chk("pkt_count_after_8", pkt_count, 2);
    finish_stream(4);
    start(0, 32'h1000, 4, 0);
    repeat (40) tick();
    chk("bp_fifo_full", fifo_count, 16);
    chk("bp_busy", busy, 1);
    tready = 1;
    wait_pop(30);
    finish_stream(4);
    start(0, 32'h200, 5, 1);
    wait_pop(2);
    enable = 0;
    finish_stream(5);
    chk("midstop_words", n_pop, 5);
    chk("midstop_busy", busy, 0);
    start(1, 0, 8, 1);
    chk("pin_lfsr_w0", exp_data[0], 1);
    chk("pin_lfsr_w1", exp_data[1], 32'h80200003);
    chk("pin_lfsr_w2", exp_data[2], 32'hC0300002);
    wait_pop(20);
    finish_stream(8);
    start(2, 32'hA5, 0, 1);
    chk("pin_const_w3", exp_data[3], 32'hA5);
    chk("pin_const_last", exp_last[3], 1);
    wait_pop(6);
    finish_stream(1);
    start(3, 5, 3, 1);
    chk("pin_mode3_w1", exp_data[1], 6);
    wait_pop(6);
    finish_stream(3);
    start(0, 32'h300, 4, 0);
    t = 0;
    while (fifo_count != 7 && t < 100) begin
      tick();
      t++;
    end
    chk("rst_fill_7", fifo_count, 7);
    mon_en = 0;
    aresetn = 0;
    #1;
    chk("arst_tvalid", tvalid, 0);
    chk("arst_fifo_count", fifo_count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pkt_count", pkt_count, 0);
    chk("arst_tdata", tdata, 0);
    enable = 0;
    repeat (2) tick();
    aresetn = 1;
    model_pkts = 0;
    repeat (3) tick();
    mon_en = 1;
    start(0, 32'h55, 4, 1);
    chk("pin_post_rst_w0", exp_data[0], 32'h55);
    wait_pop(4);
    finish_stream(4);
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
